// File: rtl/programmable_counter_if.sv
// Control/data bundle for programmable_counter: count controls in, count value and flags out.
interface programmable_counter_if #(
  parameter int unsigned WIDTH = 64
);
  logic             Enable;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic [WIDTH-1:0] Step;
  logic             Down;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] Limit;
  logic [WIDTH-1:0] Q;
  logic             TerminalCount;
  logic             Overflow;

  modport master (
    output Enable, Load, LoadValue, Step, Down, Mode, Limit,
    input  Q, TerminalCount, Overflow
  );

  modport slave (
    input  Enable, Load, LoadValue, Step, Down, Mode, Limit,
    output Q, TerminalCount, Overflow
  );
endinterface

// File: rtl/programmable_counter.sv
// Up/down counter with programmable step and wrap, modulo or saturating terminal behaviour.
module programmable_counter #(
  parameter int unsigned          WIDTH       = 64,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  programmable_counter_if.slave bus
);

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_MOD  = 2'b01;
  localparam logic [1:0] MODE_SAT  = 2'b10;
  localparam logic [1:0] MODE_RSV  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             ov_q, ov_d;
  logic [WIDTH:0]   sum, diff;
  logic             carry, borrow, above_limit, bounded_mode;

  // One extra bit on both results: bit WIDTH is carry (up) or borrow (down).
  always_comb begin
    sum          = {1'b0, q_q} + {1'b0, bus.Step};
    diff         = {1'b0, q_q} - {1'b0, bus.Step};
    carry        = sum[WIDTH];
    borrow       = diff[WIDTH];
    above_limit  = sum > {1'b0, bus.Limit};
    bounded_mode = (bus.Mode == MODE_MOD) || (bus.Mode == MODE_SAT);
  end

  always_comb begin
    q_d  = q_q;
    ov_d = 1'b0;
    if (bus.Load) begin
      q_d = (bounded_mode && (bus.LoadValue > bus.Limit)) ? bus.Limit : bus.LoadValue;
    end else if (bus.Enable && (bus.Mode != MODE_RSV) && (bus.Step != '0)) begin
      case (bus.Mode)
        MODE_WRAP: begin
          q_d  = bus.Down ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
          ov_d = bus.Down ? borrow : carry;
        end
        MODE_MOD: begin
          if (bus.Down) begin
            q_d  = borrow ? bus.Limit : diff[WIDTH-1:0];
            ov_d = borrow;
          end else begin
            q_d  = above_limit ? '0 : sum[WIDTH-1:0];
            ov_d = above_limit;
          end
        end
        MODE_SAT: begin
          if (bus.Down) begin
            q_d  = borrow ? '0 : diff[WIDTH-1:0];
            ov_d = borrow;
          end else begin
            q_d  = above_limit ? bus.Limit : sum[WIDTH-1:0];
            ov_d = above_limit;
          end
        end
        default: begin
          q_d  = q_q;
          ov_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q  <= RESET_VALUE;
      ov_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      ov_q <= ov_d;
    end
  end

  always_comb begin
    bus.TerminalCount = 1'b0;
    if (bus.Mode != MODE_RSV) begin
      if (bus.Down)                  bus.TerminalCount = (q_q == '0);
      else if (bus.Mode == MODE_WRAP) bus.TerminalCount = (q_q == '1);
      else                           bus.TerminalCount = (q_q == bus.Limit);
    end
  end

  assign bus.Q        = q_q;
  assign bus.Overflow = ov_q;

endmodule

// File: doc/programmable_counter.md
PROGRAMMABLE_COUNTER -- requirements
Module: programmable_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, counter and data width in bits.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, value loaded into Q on reset.
REQ-003 The block SHALL have port Clock, input, 1, single clock; all state changes on rising edge.
REQ-004 The block SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port Enable, input, 1, count one step this cycle when high.
REQ-006 The block SHALL have port Load, input, 1, parallel load of LoadValue when high.
REQ-007 The block SHALL have port LoadValue, input, WIDTH, parallel load data.
REQ-008 The block SHALL have port Step, input, WIDTH, unsigned increment/decrement amount.
REQ-009 The block SHALL have port Down, input, 1, 0 = count up, 1 = count down.
REQ-010 The block SHALL have port Mode, input, 2, 00 wrap, 01 modulo, 10 saturate, 11 reserved.
REQ-011 The block SHALL have port Limit, input, WIDTH, upper bound for modulo/saturate modes.
REQ-012 The block SHALL have port Q, output, WIDTH, registered count value.
REQ-013 The block SHALL have port TerminalCount, output, 1, combinational terminal-value flag.
REQ-014 The block SHALL have port Overflow, output, 1, registered one-cycle wrap/clamp event pulse.

Function
REQ-015 Per-edge priority SHALL be: Reset > Load > (Enable and Mode != 11) count > hold.
REQ-016 Q SHALL update only on a rising Clock edge; the new value SHALL be visible one cycle after the controlling inputs are sampled (latency 1).
REQ-017 Arithmetic SHALL be unsigned, computed WIDTH+1 bits wide; carry/borrow SHALL drive the wrap/clamp decisions.
REQ-018 Mode 00, up: Q <= (Q + Step) mod 2^WIDTH; Overflow SHALL pulse when a carry out occurs.
REQ-019 Mode 00, down: Q <= (Q - Step) mod 2^WIDTH; Overflow SHALL pulse when a borrow occurs.
REQ-020 Mode 01, up: if Q + Step > Limit, Q <= 0 and Overflow pulses; otherwise Q <= Q + Step.
REQ-021 Mode 01, down: if Q < Step, Q <= Limit and Overflow pulses; otherwise Q <= Q - Step.
REQ-022 Mode 10, up: Q <= min(Q + Step, Limit); Overflow SHALL pulse only when clamping occurs.
REQ-023 Mode 10, down: Q <= max(Q - Step, 0); Overflow SHALL pulse only when clamping occurs.
REQ-024 Mode 11: Q SHALL hold, Overflow SHALL be 0, and Load SHALL still apply.
REQ-025 Load: Q <= LoadValue; in modes 01/10, LoadValue > Limit SHALL load Limit instead; Load SHALL never raise Overflow.
REQ-026 Step = 0 with Enable high: Q SHALL hold and Overflow SHALL be 0.
REQ-027 Overflow SHALL be high for exactly the one cycle following the triggering edge and 0 otherwise.
REQ-028 TerminalCount, up: Q == Limit (modes 01/10) or Q == 2^WIDTH-1 (mode 00); down: Q == 0; mode 11: 0.
REQ-029 Limit, Mode, Down and Step SHALL be sampled every edge; changing them mid-count SHALL take effect on the next count with no extra state.
REQ-030 In mode 01/10, if Q > Limit (Limit lowered while counting): an up-count SHALL produce 0 (01) or Limit (10) with an Overflow pulse; a down-count SHALL follow REQ-021/REQ-023.

Reset
REQ-031 On a rising edge with Reset high: Q <= RESET_VALUE and Overflow <= 0, regardless of Load/Enable.
REQ-032 Reset asserted mid-count SHALL take effect at that edge; counting SHALL resume from RESET_VALUE on the first edge after Reset deasserts.
REQ-033 Between power-up and the first Reset edge, output values are don't-care.

Verification
REQ-034 WIDTH=64, Mode=00, Up, Step=4, Enable=1 after reset -> Q = 0, 4, 8, 12 on consecutive cycles; Overflow 0.
REQ-035 WIDTH=8, Mode=00, Up, Step=4, Load 252 then count -> Q = 252, then 0 with Overflow=1 for one cycle.
REQ-036 WIDTH=8, Mode=01, Limit=9, Step=3, Up from 0 -> Q = 0,3,6,9,0 with Overflow on the wrap; TerminalCount=1 while Q=9.
REQ-037 WIDTH=8, Mode=10, Down, Step=5, Load 7 -> Q = 7, 2, 0 (Overflow pulse), 0 (Overflow pulse); TerminalCount=1 at 0.
REQ-038 WIDTH=8, Mode=01, Limit=20, Load 50 -> Q=20; same-edge Load and Enable -> load wins; Reset with Load -> Q=RESET_VALUE.
REQ-039 WIDTH=8, Mode=00, Step=0 or Mode=11 with Enable=1 -> Q holds for 3 cycles; Overflow stays 0.
